// File: rtl/addsub_seq_unit.sv
// addsub_seq_unit: multi-cycle chunked add/subtract with valid/ready handshake and accumulate mode.
// Optional build macro SATURATE_EN clamps s to the signed range when the operation overflows.
module addsub_seq_unit #(
  parameter int WIDTH = 13,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             acc_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             carry_out
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_q, w_d, s_q, s_d, w_n, sat;
  logic [IW-1:0] idx_q, idx_d;
  logic cy_q, cy_d, ov_q, ov_d, co_q, co_d, cy_n, ov_n, last;
  logic [CHUNK-1:0] ac, bc;
  logic [CHUNK:0] csum, cs_sh, cm_sh;
  int lo, len;
  // Chunk datapath: len clips the final partial chunk, so its carry sits at bit len.
  always_comb begin
    lo = int'(idx_q) * CHUNK;
    len = (WIDTH - lo > CHUNK) ? CHUNK : WIDTH - lo;
    ac = CHUNK'(a_q >> lo);
    bc = CHUNK'(b_q >> lo);
    csum = {1'b0, ac} + {1'b0, bc} + {{CHUNK{1'b0}}, cy_q};
    cs_sh = csum >> len;
    cy_n = cs_sh[0];
    cm_sh = (csum ^ {1'b0, ac} ^ {1'b0, bc}) >> (len - 1);
    ov_n = cm_sh[0] ^ cy_n;
    w_n = w_q | (WIDTH'(csum[CHUNK-1:0]) << lo);
    last = idx_q == IW'(NCHUNK - 1);
`ifdef SATURATE_EN
    sat = ov_n ? (a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : w_n;
`else
    sat = w_n;
`endif
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    w_d = w_q;
    idx_d = idx_q;
    cy_d = cy_q;
    s_d = s_q;
    ov_d = ov_q;
    co_d = co_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      a_d = acc_mode ? s_q : x;
      b_d = y ^ {WIDTH{sub}};
      cy_d = sub;
      idx_d = '0;
      w_d = '0;
    end else if (state_q == RUN) begin
      w_d = w_n;
      cy_d = cy_n;
      idx_d = idx_q + IW'(1);
      if (last) begin
        state_d = DONE;
        s_d = sat;
        ov_d = ov_n;
        co_d = cy_n;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      w_q <= '0;
      idx_q <= '0;
      cy_q <= 1'b0;
      s_q <= '0;
      ov_q <= 1'b0;
      co_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      w_q <= w_d;
      idx_q <= idx_d;
      cy_q <= cy_d;
      s_q <= s_d;
      ov_q <= ov_d;
      co_q <= co_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign s = s_q;
  assign overflow = ov_q;
  assign carry_out = co_q;
endmodule

// File: tb/tb_addsub_seq_unit.sv
// tb_addsub_seq_unit: directed checks of addsub_seq_unit with CHUNK=4, 13 and 1 run in lockstep.
module tb_addsub_seq_unit;
  logic clk = 1'b0;
  logic rst_n, in_valid, sub, acc_mode, out_ready;
  logic [12:0] x, y;
  logic [2:0] in_rdy, out_vld, ovf, cout;
  logic [12:0] s_o [3];
  int errors = 0, checks = 0;
  int lat [3];
  always #5 clk = ~clk;
  addsub_seq_unit #(.WIDTH(13), .CHUNK(4)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_rdy[0]), .x(x), .y(y), .sub(sub), .acc_mode(acc_mode), .out_valid(out_vld[0]),
    .out_ready(out_ready), .s(s_o[0]), .overflow(ovf[0]), .carry_out(cout[0]));
  addsub_seq_unit #(.WIDTH(13), .CHUNK(13)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_rdy[1]), .x(x), .y(y), .sub(sub), .acc_mode(acc_mode), .out_valid(out_vld[1]),
    .out_ready(out_ready), .s(s_o[1]), .overflow(ovf[1]), .carry_out(cout[1]));
  addsub_seq_unit #(.WIDTH(13), .CHUNK(1)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_rdy[2]), .x(x), .y(y), .sub(sub), .acc_mode(acc_mode), .out_valid(out_vld[2]),
    .out_ready(out_ready), .s(s_o[2]), .overflow(ovf[2]), .carry_out(cout[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // Issue one command; latency counts edges from the accept edge (inclusive) to out_valid.
  task automatic run(input logic [12:0] xv, input logic [12:0] yv, input logic sb, input logic am);
    int n;
    @(negedge clk);
    x = xv; y = yv; sub = sb; acc_mode = am; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    lat = '{0, 0, 0};
    while (!(&out_vld) && n < 40) begin
      @(posedge clk); #1;
      n++;
      for (int i = 0; i < 3; i++) if (out_vld[i] && lat[i] == 0) lat[i] = n + 1;
    end
    check("done_timeout", {31'b0, &out_vld}, 32'd1);
  endtask
  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_out_valid", {29'b0, out_vld}, 32'd0);
    check("handoff_in_ready", {29'b0, in_rdy}, 32'd7);
  endtask
  task automatic check_all(input string tag, input logic [12:0] es, input logic eo, input logic ec);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_s"}, {19'b0, s_o[i]}, {19'b0, es});
      check({tag, "_ovf"}, {31'b0, ovf[i]}, {31'b0, eo});
      check({tag, "_cout"}, {31'b0, cout[i]}, {31'b0, ec});
    end
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; acc_mode = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {29'b0, in_rdy}, 32'd7);
    check("rst_out_valid", {29'b0, out_vld}, 32'd0);
    check_all("rst", 13'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(13'd100, 13'd23, 1'b0, 1'b0);
    check("lat_chunk4", lat[0], 32'd5);
    check("lat_chunk13", lat[1], 32'd2);
    check("lat_chunk1", lat[2], 32'd14);
    check_all("add", 13'd123, 1'b0, 1'b0);
    release_out();
    run(13'd5, 13'd7, 1'b1, 1'b0);
    check_all("sub_neg", 13'h1FFE, 1'b0, 1'b0);
    release_out();
    run(13'd7, 13'd5, 1'b1, 1'b0);
    check_all("sub_pos", 13'd2, 1'b0, 1'b1);
    release_out();
    run(13'h0FFF, 13'd1, 1'b0, 1'b0);
`ifdef SATURATE_EN
    check_all("ovf_pos", 13'h0FFF, 1'b1, 1'b0);
`else
    check_all("ovf_pos", 13'h1000, 1'b1, 1'b0);
`endif
    release_out();
    run(13'h1000, 13'd1, 1'b1, 1'b0);
`ifdef SATURATE_EN
    check_all("ovf_neg", 13'h1000, 1'b1, 1'b1);
`else
    check_all("ovf_neg", 13'h0FFF, 1'b1, 1'b1);
`endif
    release_out();
    run(13'd10, 13'd0, 1'b0, 1'b0);
    check_all("acc0", 13'd10, 1'b0, 1'b0);
    release_out();
    run(13'd999, 13'd5, 1'b0, 1'b1);
    check_all("acc1", 13'd15, 1'b0, 1'b0);
    release_out();
    run(13'd999, 13'd20, 1'b1, 1'b1);
    check_all("acc2", 13'h1FFB, 1'b0, 1'b0);
    release_out();
    run(13'd3, 13'd4, 1'b0, 1'b0);
    // Hold the result while a conflicting command sits on the input.
    @(negedge clk);
    x = 13'd999; y = 13'd1; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("bp_s", {19'b0, s_o[0]}, 32'd7);
      check("bp_ovf", {29'b0, ovf}, 32'd0);
      check("bp_out_valid", {29'b0, out_vld}, 32'd7);
      check("bp_in_ready", {29'b0, in_rdy}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    check("bp_s_kept", {19'b0, s_o[0]}, 32'd7);
    @(negedge clk);
    x = 13'd50; y = 13'd50; sub = 1'b0; acc_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", {29'b0, in_rdy}, 32'd7);
    check("midrst_out_valid", {29'b0, out_vld}, 32'd0);
    check_all("midrst", 13'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(13'd1, 13'd1, 1'b0, 1'b0);
    check_all("post_rst", 13'd2, 1'b0, 1'b0);
    release_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
